// File: rtl/cpu_pkg.sv
// cpu_pkg: definitions shared by the CPU front end.
//   XLEN             - architectural PC / instruction width
//   RESET_PC_DEFAULT - default PC loaded when rst is asserted
//   PC_STEP          - byte distance between sequential instruction words
//   fetch_entry_t    - one buffered fetch result, packed as {inst, pc}
package cpu_pkg;

  localparam int XLEN = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int PC_STEP = 4;

  // Same {inst, pc} layout that fetch_queue pushes into its FIFO.
  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: small synchronous FIFO that buffers fetched {inst, pc} entries.
// Ports:
//   clk, rst   - clock, asynchronous active-high reset
//   push       - write push_data at the tail this cycle
//   push_data  - entry to write
//   pop        - drop the head entry this cycle (caller only pops when non-empty)
//   flush      - discard every entry; has priority over push and pop
//   head       - current head entry (meaningless while count == 0)
//   count      - number of stored entries, 0..DEPTH
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit so that full (DEPTH) and empty (0)
  // give different pointer differences.
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];

  // Pointer update: flush rewinds both pointers, otherwise push and pop
  // advance independently so they can share a cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage is never reset; the head is only observed while count != 0.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  assign head  = mem[rd_ptr[AW-1:0]];
  assign count = wr_ptr - rd_ptr;

endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: decoupled instruction-fetch front end.
// Issues sequential word reads to a 1-cycle synchronous instruction memory,
// buffers the returned instructions in fetch_fifo and hands them to decode
// over a valid/ready handshake. Redirects flush the wrong-path stream.
// Ports:
//   clk, rst                   - clock, asynchronous active-high reset
//   redirect_valid/redirect_pc - load a new fetch PC (bits [1:0] ignored)
//   imem_addr/imem_en          - word address and read request to imem
//   imem_rdata                 - imem read data, one cycle after imem_en
//   out_valid/out_ready        - decode handshake
//   out_inst/out_pc            - head instruction and its PC (0 while empty)
//   out_next_pc                - out_pc + 4 (0 while empty)
module fetch_queue #(
  parameter int               XLEN     = cpu_pkg::XLEN,
  parameter int               IMEM_AW  = 6,
  parameter int               DEPTH    = 2,
  parameter logic [XLEN-1:0]  RESET_PC = XLEN'(cpu_pkg::RESET_PC_DEFAULT)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               redirect_valid,
  input  logic [XLEN-1:0]    redirect_pc,
  output logic [IMEM_AW-1:0] imem_addr,
  output logic               imem_en,
  input  logic [XLEN-1:0]    imem_rdata,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    out_inst,
  output logic [XLEN-1:0]    out_pc,
  output logic [XLEN-1:0]    out_next_pc
);

  import cpu_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = 2 * XLEN;

  logic [XLEN-1:0] pc;
  logic            inflight;
  logic [XLEN-1:0] inflight_pc;
  logic            inflight_epoch;
  logic            epoch;

  logic [CW-1:0]   count;
  logic [CW-1:0]   count_after_pop;
  logic            pop;
  logic            push;
  logic            issue;
  logic [EW-1:0]   head;
  logic [XLEN-1:0] head_pc;
  logic            unused_redirect_bits;

  assign unused_redirect_bits = ^redirect_pc[1:0];

  assign out_valid       = (count != '0);
  assign pop             = out_valid && out_ready;
  assign count_after_pop = count - CW'(pop);

  // Credit check: an issue is only allowed when the FIFO can hold both the
  // response already on its way and the new one, so nothing is ever dropped.
  assign issue = !rst && !redirect_valid &&
                 ((int'(count_after_pop) + int'(inflight) + 1) <= DEPTH);

  // A response arriving in a redirect cycle was fetched on the old path, so
  // the flush wins over the push even though the epochs still match.
  assign push = inflight && (inflight_epoch == epoch) && !redirect_valid;

  assign imem_en   = issue;
  assign imem_addr = pc[IMEM_AW+1:2];

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({imem_rdata, inflight_pc}),
    .pop       (pop),
    .flush     (redirect_valid),
    .head      (head),
    .count     (count)
  );

  // Fetch PC and in-flight tracking. A read issued this cycle returns next
  // cycle, so inflight simply mirrors issue; the epoch tags it so that a
  // response from before a redirect is recognised as wrong-path.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc             <= RESET_PC;
      inflight       <= 1'b0;
      inflight_pc    <= '0;
      inflight_epoch <= 1'b0;
      epoch          <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        inflight_pc    <= pc;
        inflight_epoch <= epoch;
      end
      if (redirect_valid) begin
        pc    <= {redirect_pc[XLEN-1:2], 2'b00};
        epoch <= ~epoch;
      end else if (issue) begin
        pc <= pc + XLEN'(PC_STEP);
      end
    end
  end

  // Head fields are gated to zero while the FIFO is empty.
  assign head_pc     = head[XLEN-1:0];
  assign out_inst    = out_valid ? head[EW-1:XLEN] : '0;
  assign out_pc      = out_valid ? head_pc : '0;
  assign out_next_pc = out_valid ? (head_pc + XLEN'(PC_STEP)) : '0;

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Parametrised instruction-fetch front end: replaces the single-PC fetcher with a decoupled fetch unit. It issues sequential word reads to a synchronous instruction memory and buffers returned instructions in a small FIFO. It presents them to decode over a valid/ready handshake. It accepts PC redirects from execute, flushing wrong-path instructions, so that neither a stalled decode nor a branch corrupts the fetch stream.

## Interface
Parameters:
- XLEN, 32: PC and instruction width.
- IMEM_AW, 6: instruction memory word-address width (depth 2^IMEM_AW words).
- DEPTH, 2: FIFO entries, power of two, ≥2.
- RESET_PC, 32'h0: PC loaded at reset.

Ports:
- clk, in, 1: clock, all state on rising edge.
- rst, in, 1: reset, asynchronous, active-high.
- redirect_valid, in, 1: load new fetch PC this cycle.
- redirect_pc, in, XLEN: target PC. Bits [1:0] are ignored and treated as 0.
- imem_addr, out, IMEM_AW: word address, equal to pc[IMEM_AW+1:2].
- imem_en, out, 1: read request this cycle.
- imem_rdata, in, XLEN: read data, valid exactly one cycle after imem_en.
- out_valid, out, 1: FIFO head holds an instruction.
- out_ready, in, 1: decode accepts the head.
- out_inst, out, XLEN: head instruction.
- out_pc, out, XLEN: PC of head instruction.
- out_next_pc, out, XLEN: out_pc + 4, mod 2^XLEN.

## Operation
- State: pc register, FIFO of {inst, pc} entries, count, one in-flight flag with its PC, epoch bit.
- Credit rule: imem_en = !rst && !redirect_valid && (count + inflight + 1 ≤ DEPTH), where count is the value after any pop this cycle. With this rule the FIFO never overflows and no response is dropped for lack of space.
- On issue: inflight ← 1, inflight_pc ← pc, inflight_epoch ← epoch, pc ← pc + 4. Increment wraps at 2^XLEN; imem_addr wraps at 2^IMEM_AW words.
- On response (cycle after issue):
  - if inflight_epoch == epoch, push {imem_rdata, inflight_pc};
  - otherwise discard the response.
  - inflight clears unless a new issue occurs in the same cycle.
- Pop: occurs when out_valid && out_ready. Push and pop in the same cycle are both allowed, including when the FIFO is full with credit permitting a push.
- Redirect (redirect_valid = 1):
  - pc ← {redirect_pc[XLEN-1:2], 2'b00};
  - FIFO emptied (count ← 0);
  - epoch toggles;
  - no issue this cycle.
  - A handshake in the same cycle still completes: decode has consumed that head, then the flush applies.
  - Back-to-back redirects: the last one wins.
- Outputs out_inst, out_pc and out_next_pc are driven from the FIFO head and are stable while out_valid && !out_ready.
- Reset values:
  - pc = RESET_PC;
  - count = 0, out_valid = 0;
  - inflight = 0, epoch = 0, imem_en = 0;
  - out_inst, out_pc, out_next_pc = 0 while empty (gated).
- Reset asserted mid-stream clears everything immediately, including an in-flight read. Its returning data is ignored because inflight = 0.

## Timing
- First fetch after reset release: issue in cycle 0 at RESET_PC, data pushed at the end of cycle 1, out_valid = 1 in cycle 2. Fetch-to-decode latency is 2 cycles.
- Steady state with out_ready held at 1: one instruction per cycle, PCs consecutive.
- Redirect in cycle t:
  - out_valid = 0 in t+1 and t+2;
  - issue at the target in t+1;
  - target instruction valid in t+3 (3-cycle bubble).
- out_ready low: FIFO fills to DEPTH, after which imem_en = 0. Once out_ready returns, issuing resumes the same cycle, because the pop frees credit.

## Structure
- Shared package cpu_pkg: XLEN, the RESET_PC default, and a typedef fetch_entry_t = {inst, pc}.
- Sub-module fetch_fifo:
  - parametrised on DEPTH and entry width;
  - push/pop/flush ports with count output;
  - pointer width log2(DEPTH) + 1 for full/empty detection.
- The top level holds pc, the in-flight/epoch tracking and the credit logic.
- The instruction memory stays outside the block. The bench models it as a 1-cycle synchronous ROM with word[i] = 32'h1000_0000 + i.

## Test plan
- Reset release, out_ready = 1:
  - out_valid rises in cycle 2;
  - out_pc sequence 0, 4, 8, 12;
  - out_inst 0x10000000, 0x10000001, …
- out_ready = 0 for 10 cycles, DEPTH = 2:
  - imem_en drops after 2 issues;
  - head out_pc = 0 held stable;
  - after release, 0, 4, 8 are delivered with no gap and no duplicate.
- Redirect to 0x40 while an in-flight read of 0x8 is pending:
  - the 0x8 data is never presented;
  - next out_pc = 0x40, three cycles after the redirect.
- Redirect with redirect_pc = 0x43 in the same cycle as a handshake at PC 4:
  - PC 4 counts as consumed;
  - next out_pc = 0x40.
- Wrap: redirect to 0xFC with IMEM_AW = 6:
  - imem_addr goes 63 → 0;
  - out_pc goes 0xFC then 0x100.
- rst pulsed asynchronously mid-stream:
  - out_valid goes to 0 immediately;
  - the first out_pc after release is RESET_PC, with no stale instruction.
